// File: rtl/shift_issue_stage.sv
// Decode of RV32I shift ops into Shifter controls, behind a 2-entry (main + skid) buffer.
// Optional operand bypass from writeback is enabled by defining SHIFT_OPERAND_BYPASS_EN.
module shift_issue_stage #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [6:0]       in_opcode,
   input  logic [2:0]       in_funct3,
   input  logic [6:0]       in_funct7,
   input  logic [4:0]       in_rs2_field,
   input  logic [XLEN-1:0]  in_rs1_val,
   input  logic [XLEN-1:0]  in_rs2_val,
   input  logic [4:0]       in_rd,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_sra,
   output logic             out_sll,
   output logic [4:0]       out_size,
   output logic [XLEN-1:0]  out_in,
   output logic [4:0]       out_rd,
   output logic [TAG_W-1:0] out_tag,
`ifdef SHIFT_OPERAND_BYPASS_EN
   input  logic [4:0]       in_rs1_idx,
   input  logic [4:0]       in_rs2_idx,
   input  logic             wb_valid,
   input  logic [4:0]       wb_rd,
   input  logic [XLEN-1:0]  wb_data,
`endif
   output logic             illegal
);

   localparam logic [6:0] OP_REG = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam int         ENT_W  = 2 + 5 + XLEN + 5 + TAG_W;

   // Returns {legal, sra, sll}; sll and sra are never both set.
   function automatic logic [2:0] decode(input logic [6:0] opcode,
                                         input logic [2:0] funct3,
                                         input logic [6:0] funct7);
      logic is_shift_op;
      is_shift_op = (opcode == OP_REG) || (opcode == OP_IMM);
      if (is_shift_op && funct3 == 3'b001 && funct7 == 7'b0000000)
         return 3'b101;
      else if (is_shift_op && funct3 == 3'b101 && funct7 == 7'b0000000)
         return 3'b100;
      else if (is_shift_op && funct3 == 3'b101 && funct7 == 7'b0100000)
         return 3'b110;
      else
         return 3'b000;
   endfunction

   logic [XLEN-1:0]  rs1_eff_p0;
   logic [XLEN-1:0]  rs2_eff_p0;
   logic [2:0]       dec_p0;
   logic [4:0]       size_p0;
   logic [ENT_W-1:0] new_ent_p0;
   logic             accept_p0;
   logic             wr_p0;
   logic             drain_p0;

   logic             main_vld_p1;
   logic             skid_vld_p1;
   logic [ENT_W-1:0] main_ent_p1;
   logic [ENT_W-1:0] skid_ent_p1;
   logic             illegal_p1;
   logic             unused_rs2_hi;

   always_comb begin
      rs1_eff_p0 = in_rs1_val;
      rs2_eff_p0 = in_rs2_val;
`ifdef SHIFT_OPERAND_BYPASS_EN
      // Only the op being accepted is patched; buffered entries keep their operands.
      if (wb_valid && wb_rd != 5'd0 && wb_rd == in_rs1_idx)
         rs1_eff_p0 = wb_data;
      if (in_opcode == OP_REG && wb_valid && wb_rd != 5'd0 && wb_rd == in_rs2_idx)
         rs2_eff_p0 = wb_data;
`endif
   end

   assign unused_rs2_hi = ^rs2_eff_p0[XLEN-1:5];
   assign dec_p0      = decode(in_opcode, in_funct3, in_funct7);
   assign size_p0     = (in_opcode == OP_REG) ? rs2_eff_p0[4:0] : in_rs2_field;
   assign new_ent_p0  = {dec_p0[1], dec_p0[0], size_p0, rs1_eff_p0, in_rd, in_tag};
   assign accept_p0   = in_valid & in_ready & ~flush;
   assign wr_p0       = accept_p0 & dec_p0[2];
   assign drain_p0    = main_vld_p1 & out_ready;

   // ---- stage p0 -> p1: main/skid entries ----
   always_ff @(posedge clk) begin
      if (rst) begin
         main_vld_p1 <= 1'b0;
         skid_vld_p1 <= 1'b0;
         main_ent_p1 <= '0;
         skid_ent_p1 <= '0;
         illegal_p1  <= 1'b0;
      end else if (flush) begin
         main_vld_p1 <= 1'b0;
         skid_vld_p1 <= 1'b0;
         illegal_p1  <= 1'b0;
      end else begin
         illegal_p1 <= accept_p0 & ~dec_p0[2];
         if (drain_p0) begin
            // in_ready is low whenever skid holds an op, so no accept collides with the refill.
            if (skid_vld_p1) begin
               main_ent_p1 <= skid_ent_p1;
               skid_vld_p1 <= 1'b0;
            end else if (wr_p0) begin
               main_ent_p1 <= new_ent_p0;
            end else begin
               main_vld_p1 <= 1'b0;
            end
         end else if (wr_p0) begin
            if (!main_vld_p1) begin
               main_vld_p1 <= 1'b1;
               main_ent_p1 <= new_ent_p0;
            end else begin
               skid_vld_p1 <= 1'b1;
               skid_ent_p1 <= new_ent_p0;
            end
         end
      end
   end

   assign in_ready  = ~skid_vld_p1;
   assign out_valid = main_vld_p1;
   assign illegal   = illegal_p1;
   assign {out_sra, out_sll, out_size, out_in, out_rd, out_tag} = main_ent_p1;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Scoreboard bench for shift_issue_stage: directed scenarios plus randomized traffic.
// Define SHIFT_OPERAND_BYPASS_EN to also exercise the writeback bypass.
module tb_shift_issue_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [6:0]  in_opcode = '0;
   logic [2:0]  in_funct3 = '0;
   logic [6:0]  in_funct7 = '0;
   logic [4:0]  in_rs2_field = '0;
   logic [31:0] in_rs1_val = '0;
   logic [31:0] in_rs2_val = '0;
   logic [4:0]  in_rd = '0;
   logic [3:0]  in_tag = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        out_sra, out_sll;
   logic [4:0]  out_size;
   logic [31:0] out_in;
   logic [4:0]  out_rd;
   logic [3:0]  out_tag;
   logic        illegal;
`ifdef SHIFT_OPERAND_BYPASS_EN
   logic [4:0]  in_rs1_idx = '0;
   logic [4:0]  in_rs2_idx = '0;
   logic        wb_valid = 1'b0;
   logic [4:0]  wb_rd = '0;
   logic [31:0] wb_data = '0;
`endif

   shift_issue_stage #(.XLEN(32), .TAG_W(4)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
      .in_rs2_field(in_rs2_field), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
      .in_rd(in_rd), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sra(out_sra), .out_sll(out_sll), .out_size(out_size),
      .out_in(out_in), .out_rd(out_rd), .out_tag(out_tag),
`ifdef SHIFT_OPERAND_BYPASS_EN
      .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
`endif
      .illegal(illegal)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        sra;
      logic        sll;
      logic [4:0]  size;
      logic [31:0] val;
      logic [4:0]  rd;
      logic [3:0]  tag;
   } op_t;

   op_t  q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   logic exp_ill = 1'b0;
   logic prev_rst = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: what the Shifter should receive for this instruction, if anything.
   function automatic logic model(input logic [6:0] opc, input logic [2:0] f3,
                                  input logic [6:0] f7, input logic [4:0] rs2f,
                                  input logic [31:0] rs1, input logic [31:0] rs2,
                                  input logic [4:0] rd, input logic [3:0] tag,
                                  output op_t o);
      string kind;
      o = '0;
      if (opc != 7'h33 && opc != 7'h13) return 1'b0;
      case ({f3, f7})
         {3'd1, 7'h00}: kind = "SLL";
         {3'd5, 7'h00}: kind = "SRL";
         {3'd5, 7'h20}: kind = "SRA";
         default:       kind = "";
      endcase
      if (kind == "") return 1'b0;
      o.sll  = (kind == "SLL");
      o.sra  = (kind == "SRA");
      o.size = (opc == 7'h33) ? 5'(rs2 % 32) : rs2f;
      o.val  = rs1;
      o.rd   = rd;
      o.tag  = tag;
      return 1'b1;
   endfunction

   // Monitor: checks outputs against the model's view of the buffered ops, then
   // applies whatever the coming edge will do (flush, drain, accept).
   always @(negedge clk) begin
      op_t  e;
      logic legal, acc, drn;
      logic [31:0] rs1, rs2;
      if (rst) begin
         q.delete();
         exp_ill  = 1'b0;
         prev_rst = 1'b1;
      end else begin
         check("out_valid", 64'(out_valid), 64'(q.size() != 0));
         check("in_ready", 64'(in_ready), 64'(q.size() < 2));
         check("illegal", 64'(illegal), 64'(exp_ill));
         if (prev_rst)
            check("reset_data", 64'({out_sra, out_sll, out_size, out_in, out_rd, out_tag}), 64'd0);
         if (out_valid && q.size() != 0)
            check("out_op", 64'({out_sra, out_sll, out_size, out_in, out_rd, out_tag}), 64'(q[0]));
         rs1 = in_rs1_val;
         rs2 = in_rs2_val;
`ifdef SHIFT_OPERAND_BYPASS_EN
         if (wb_valid && wb_rd != 0 && wb_rd == in_rs1_idx) rs1 = wb_data;
         if (in_opcode == 7'h33 && wb_valid && wb_rd != 0 && wb_rd == in_rs2_idx) rs2 = wb_data;
`endif
         legal = model(in_opcode, in_funct3, in_funct7, in_rs2_field, rs1, rs2, in_rd, in_tag, e);
         acc   = in_valid && (q.size() < 2) && !flush;
         drn   = (q.size() != 0) && out_ready && !flush;
         if (flush) q.delete();
         else begin
            if (drn) void'(q.pop_front());
            if (acc && legal) q.push_back(e);
         end
         exp_ill  = acc && !legal;
         prev_rst = 1'b0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] rs2f, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [4:0] rd, input logic [3:0] tag);
      in_valid = 1'b1;
      in_opcode = opc; in_funct3 = f3; in_funct7 = f7; in_rs2_field = rs2f;
      in_rs1_val = rs1; in_rs2_val = rs2; in_rd = rd; in_tag = tag;
   endtask

   task automatic fill_two();
      out_ready = 1'b0;
      set_op(7'h13, 3'd1, 7'h00, 5'd1, 32'h11, 32'h0, 5'd1, 4'd1); step();
      set_op(7'h13, 3'd5, 7'h00, 5'd2, 32'h22, 32'h0, 5'd2, 4'd2); step();
      in_valid = 1'b0;
   endtask

   initial begin
      int   tries;
      logic was_ready;
      logic [1:0] pick;
      step(); step();
      rst = 1'b0;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);

      // SLLI x5,x1,3
      out_ready = 1'b1;
      set_op(7'h13, 3'd1, 7'h00, 5'd3, 32'h0000_00F1, 32'h0, 5'd5, 4'd3); step();
      in_valid = 1'b0;
      check("slli", 64'({out_valid, out_sll, out_sra, out_size, out_in, out_rd}),
            64'({1'b1, 1'b1, 1'b0, 5'd3, 32'h0000_00F1, 5'd5}));
      // SRA uses only the low 5 bits of rs2
      set_op(7'h33, 3'd5, 7'h20, 5'd0, 32'h8000_0000, 32'h0000_0024, 5'd6, 4'd4); step();
      in_valid = 1'b0;
      check("sra", 64'({out_valid, out_sra, out_sll, out_size}), 64'({1'b1, 1'b1, 1'b0, 5'd4}));
      step();

      // A,B held, C stalls, then drained in order by the monitor
      fill_two();
      set_op(7'h33, 3'd5, 7'h20, 5'd0, 32'h33, 32'd7, 5'd3, 4'd3);
      step(); step();
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_main_tag", 64'(out_tag), 64'd1);
      out_ready = 1'b1;
      tries = 0;
      was_ready = 1'b0;
      while (!was_ready && tries < 10) begin
         was_ready = in_ready;
         step();
         tries++;
      end
      check("c_accepted", 64'(was_ready), 64'd1);
      in_valid = 1'b0;
      step(); step(); step();

      // Illegal encodings
      set_op(7'h33, 3'd0, 7'h00, 5'd0, 32'h1, 32'h2, 5'd7, 4'd7); step();
      in_valid = 1'b0;
      check("add_illegal", 64'({illegal, out_valid}), 64'({1'b1, 1'b0}));
      step();
      check("illegal_pulse_end", 64'(illegal), 64'd0);
      set_op(7'h13, 3'd5, 7'h01, 5'd4, 32'h1, 32'h0, 5'd8, 4'd8); step();
      in_valid = 1'b0;
      check("srli_f7_illegal", 64'({illegal, out_valid}), 64'({1'b1, 1'b0}));

      // Flush with both entries full and an op offered
      fill_two();
      set_op(7'h13, 3'd1, 7'h00, 5'd9, 32'h99, 32'h0, 5'd9, 4'd9);
      flush = 1'b1; step();
      flush = 1'b0; in_valid = 1'b0;
      check("flush", 64'({out_valid, in_ready, illegal}), 64'({1'b0, 1'b1, 1'b0}));

      // Reset mid-stall
      fill_two();
      rst = 1'b1; step();
      rst = 1'b0;
      check("rst_mid", 64'({out_valid, in_ready, illegal, out_in, out_tag}), 64'({3'b010, 32'd0, 4'd0}));

`ifdef SHIFT_OPERAND_BYPASS_EN
      out_ready = 1'b1;
      set_op(7'h33, 3'd1, 7'h00, 5'd0, 32'hAAAA_0000, 32'd1, 5'd4, 4'd4);
      in_rs1_idx = 5'd7; wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h1234_5678; step();
      check("bypass_hit", 64'(out_in), 64'h1234_5678);
      in_rs1_idx = 5'd0; wb_rd = 5'd0; step();
      in_valid = 1'b0; wb_valid = 1'b0;
      check("bypass_x0", 64'(out_in), 64'hAAAA_0000);
`endif

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         pick = 2'($urandom_range(0, 3));
         in_valid = ($urandom_range(0, 3) != 0);
         in_opcode = (pick == 0) ? 7'($urandom) : (pick[0] ? 7'h33 : 7'h13);
         pick = 2'($urandom_range(0, 3));
         in_funct3 = (pick == 0) ? 3'($urandom) : (pick[0] ? 3'd1 : 3'd5);
         pick = 2'($urandom_range(0, 3));
         in_funct7 = (pick == 0) ? 7'($urandom) : (pick[0] ? 7'h00 : 7'h20);
         in_rs2_field = 5'($urandom);
         in_rs1_val = $urandom;
         in_rs2_val = $urandom;
         in_rd = 5'($urandom);
         in_tag = 4'($urandom);
         out_ready = ($urandom_range(0, 2) != 0);
         flush = ($urandom_range(0, 39) == 0);
         rst = ($urandom_range(0, 149) == 0);
`ifdef SHIFT_OPERAND_BYPASS_EN
         in_rs1_idx = 5'($urandom_range(0, 3));
         in_rs2_idx = 5'($urandom_range(0, 3));
         wb_valid = $urandom_range(0, 1) != 0;
         wb_rd = 5'($urandom_range(0, 3));
         wb_data = $urandom;
`endif
         step();
      end

      in_valid = 1'b0; flush = 1'b0; rst = 1'b0; out_ready = 1'b1;
      tries = 0;
      while (q.size() != 0 && tries < 20) begin
         step();
         tries++;
      end
      check("final_drain", 64'(q.size()), 64'd0);
      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
